arm_lsu: RTL

Load/store unit for the ARM core: accepts byte, halfword and word load/store requests from the execute stage and drives one port of the two-port word-addressed memory. Byte order is big-endian; byte 0 of a word is bits 31:24. Sub-word stores are performed as read-modify-write. Alignment faults and memory exceptions are reported as a fault on the response.

---
 rtl/arm_mem_pkg.sv | 18 +
 rtl/arm_lsu_if.sv | 31 +++
 rtl/arm_lsu_lane.sv | 33 +++
 rtl/arm_lsu.sv | 106 ++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared encodings and widths for the ARM load/store path.
//   SZ_BYTE/SZ_HALF/SZ_WORD : req_size encodings (3 is illegal)
//   lsu_state_e             : load/store unit FSM states
//   WADDR_W/BADDR_W         : word and byte address widths
package arm_mem_pkg;
    localparam int WADDR_W = 30;
    localparam int BADDR_W = 32;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RMW_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;
endpackage

// File: rtl/arm_lsu_if.sv
// arm_lsu_if: request/response and memory-port bundle of the load/store unit.
//   req_*  : execute-stage request handshake and payload
//   resp_* : one-cycle completion pulse with load data and fault flag
//   mem_*  : one port of the word-addressed memory (async read, posedge write)
//   slave  : the LSU side; master : the execute stage plus memory side
interface arm_lsu_if;
    import arm_mem_pkg::*;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [1:0]         req_size;
    logic               req_signed;
    logic [BADDR_W-1:0] req_addr;
    logic [31:0]        req_wdata;
    logic               resp_valid;
    logic [31:0]        resp_rdata;
    logic               resp_fault;
    logic [WADDR_W-1:0] mem_addr;
    logic [31:0]        mem_wdata;
    logic               mem_write;
    logic [31:0]        mem_rdata;
    logic               mem_excpt;
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata, mem_excpt,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wdata, mem_write
    );
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata, mem_excpt,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/arm_lsu_lane.sv
// arm_lsu_lane: big-endian lane logic shared by the load and read-modify-write paths.
//   size/sgn/lane : access width, sign-extend flag, byte address bits [1:0]
//   rword         : word read from memory
//   wdata         : low halfword of the store data
//   ldata         : extracted and extended load value
//   mdata         : rword with the addressed lane(s) replaced by store data
module arm_lsu_lane
    import arm_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [15:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);
    logic [4:0]  bshift;
    logic [4:0]  hshift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    always_comb begin
        // lane 0 sits in bits 31:24, so the bit offset is (3 - lane) * 8
        bshift = {~lane, 3'b000};
        hshift = lane[1] ? 5'd0 : 5'd16;
        byte_v = 8'(rword >> bshift);
        half_v = 16'(rword >> hshift);
        ldata  = size == SZ_BYTE ? {{24{sgn & byte_v[7]}}, byte_v} :
                 size == SZ_HALF ? {{16{sgn & half_v[15]}}, half_v} : rword;
        mdata  = size == SZ_BYTE ? (rword & ~(32'h0000_00FF << bshift)) | ({24'd0, wdata[7:0]} << bshift) :
                 size == SZ_HALF ? (rword & ~(32'h0000_FFFF << hshift)) | ({16'd0, wdata} << hshift) : rword;
    end
endmodule

// File: rtl/arm_lsu.sv
// arm_lsu: load/store unit driving one port of a word-addressed big-endian memory.
//   ALIGN_FAULT : 1 = misaligned half/word requests fault, 0 = low bits ignored
//   clk, rst    : clock and synchronous active-high reset
//   bus         : arm_lsu_if.slave carrying request, response and memory port
module arm_lsu
    import arm_mem_pkg::*;
#(
    parameter bit ALIGN_FAULT = 1'b1
) (
    input logic      clk,
    input logic      rst,
    arm_lsu_if.slave bus
);
    lsu_state_e         state_q, state_d;
    logic [BADDR_W-1:0] addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic               fault_q, fault_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        ldata, mdata;
    logic               bad;

    arm_lsu_lane u_lane (
        .size  (size_q),
        .sgn   (signed_q),
        .lane  (addr_q[1:0]),
        .rword (bus.mem_rdata),
        .wdata (wdata_q[15:0]),
        .ldata (ldata),
        .mdata (mdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            fault_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            fault_q  <= fault_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // wdata_q doubles as the memory write-data register: it holds the store
    // data from accept and is overwritten with the merged word after RMW_READ.
    always_comb begin
        bad      = bus.req_size == 2'd3 ||
                   (ALIGN_FAULT && (bus.req_size == SZ_HALF ? bus.req_addr[0] :
                                    bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00));
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        fault_d  = fault_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                addr_d   = bus.req_addr;
                size_d   = bus.req_size;
                signed_d = bus.req_signed;
                wdata_d  = bus.req_wdata;
                rdata_d  = '0;
                fault_d  = bad;
                state_d  = bad ? ST_RESP : !bus.req_write ? ST_READ :
                           bus.req_size == SZ_WORD ? ST_WRITE : ST_RMW_READ;
            end
            ST_READ: begin
                rdata_d = ldata;
                fault_d = fault_q | bus.mem_excpt;
                state_d = ST_RESP;
            end
            ST_RMW_READ: begin
                wdata_d = mdata;
                fault_d = fault_q | bus.mem_excpt;
                state_d = bus.mem_excpt ? ST_RESP : ST_WRITE;
            end
            ST_WRITE: begin
                fault_d = fault_q | bus.mem_excpt;
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = state_q == ST_IDLE;
        bus.resp_valid = state_q == ST_RESP;
        bus.resp_fault = state_q == ST_RESP && fault_q;
        bus.resp_rdata = (state_q == ST_RESP && !fault_q) ? rdata_q : '0;
        // reset gates the strobe combinationally so an interrupted store never commits
        bus.mem_write  = state_q == ST_WRITE && !rst;
        bus.mem_addr   = addr_q[BADDR_W-1:2];
        bus.mem_wdata  = wdata_q;
    end
endmodule
